fpa_operand_sequencer: RTL and testbench

Upstream control stage for the unpipelined floating-point adder.
- Accepts a stream of 16-bit IEEE754 half-precision words over a valid/ready handshake. The first word becomes operand 1 and the next word becomes operand 2.
- Holds both operands stable on the adder inputs and waits for the adder's registered result.
- Captures the sum and the overflow/underflow flags, then presents them downstream with a valid/ready handshake.
- Also flags inf/NaN-encoded operands and counts completed operations.

---
 rtl/fpa_operand_sequencer.sv | 100 ++++++++++
 tb/tb_fpa_operand_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fpa_operand_sequencer.sv
// Operand sequencer in front of the single-cycle-registered half-precision adder:
// collects two words, waits for the adder result, and hands the captured sum downstream.
module fpa_operand_sequencer #(
  parameter int CALC_WAIT = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk_34,
  input  logic             rst_34,
  input  logic             in_valid_34,
  input  logic [15:0]      in_data_34,
  output logic             in_ready_34,
  output logic [15:0]      Finput1_34,
  output logic [15:0]      Finput2_34,
  input  logic [15:0]      FPSUM_34,
  input  logic             Ovf_Flag_34,
  input  logic             Unf_Flag_34,
  output logic             res_valid_34,
  input  logic             res_ready_34,
  output logic [15:0]      res_data_34,
  output logic             res_ovf_34,
  output logic             res_unf_34,
  output logic             res_exc_34,
  output logic [CNT_W-1:0] op_cnt_34
);

  localparam int DATA_W = 16;
  localparam int WAIT_W = (CALC_WAIT < 2) ? 1 : $clog2(CALC_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CALC_WAIT - 1);

  typedef enum logic [2:0] {IN1, IN2, CALC, CAP, OUT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              exc_q;

  // All-ones exponent marks an infinity or NaN encoding.
  function automatic logic is_exc(input logic [DATA_W-1:0] w);
    return &w[14:10];
  endfunction

  always_comb begin
    state_nxt   = state;
    in_ready_34 = 1'b0;
    case (state)
      IN1: begin
        in_ready_34 = 1'b1;
        if (in_valid_34) state_nxt = IN2;
      end
      IN2: begin
        in_ready_34 = 1'b1;
        if (in_valid_34) state_nxt = CALC;
      end
      CALC:    if (wait_cnt == WAIT_LAST) state_nxt = CAP;
      CAP:     state_nxt = OUT;
      OUT:     if (res_ready_34) state_nxt = IN1;
      default: state_nxt = IN1;
    endcase
  end

  always_ff @(posedge clk_34) begin
    if (rst_34) begin
      state        <= IN1;
      wait_cnt     <= '0;
      exc_q        <= 1'b0;
      Finput1_34   <= '0;
      Finput2_34   <= '0;
      res_data_34  <= '0;
      res_ovf_34   <= 1'b0;
      res_unf_34   <= 1'b0;
      res_exc_34   <= 1'b0;
      res_valid_34 <= 1'b0;
      op_cnt_34    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IN1: if (in_valid_34) Finput1_34 <= in_data_34;
        IN2: if (in_valid_34) begin
          Finput2_34 <= in_data_34;
          exc_q      <= is_exc(Finput1_34) | is_exc(in_data_34);
          wait_cnt   <= '0;
        end
        CALC: wait_cnt <= wait_cnt + 1'b1;
        // Adder output register is valid here; operands are still held stable.
        CAP: begin
          res_data_34  <= FPSUM_34;
          res_ovf_34   <= Ovf_Flag_34;
          res_unf_34   <= Unf_Flag_34;
          res_exc_34   <= exc_q;
          res_valid_34 <= 1'b1;
        end
        OUT: if (res_ready_34) begin
          res_valid_34 <= 1'b0;
          op_cnt_34    <= op_cnt_34 + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpa_operand_sequencer.sv
// Directed bench: three sequencer instances (CALC_WAIT/CNT_W = 1/8, 1/2, 3/2),
// each with a registered behavioural adder stand-in.
module tb_fpa_operand_sequencer;

  logic        clk_34 = 1'b0;
  logic        rst_34;
  logic        in_valid [3];
  logic [15:0] in_data  [3];
  logic        res_ready[3];
  logic        in_ready [3];
  logic [15:0] fin1     [3];
  logic [15:0] fin2     [3];
  logic        res_valid[3];
  logic [15:0] res_data [3];
  logic        res_ovf  [3];
  logic        res_unf  [3];
  logic        res_exc  [3];
  logic [7:0]  op_cnt   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk_34 = ~clk_34;

  // Hand-computed sums for the operand pairs used below: {sum, ovf, unf}.
  function automatic logic [17:0] add_model(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h3C00}: return {16'h4000, 1'b0, 1'b0};
      {16'h3C00, 16'hBC00}: return {16'h0000, 1'b0, 1'b1};
      {16'h7BFF, 16'h7BFF}: return {16'h0000, 1'b1, 1'b0};
      {16'h7C00, 16'h3C00}: return {16'h7C00, 1'b0, 1'b0};
      {16'h4000, 16'h4000}: return {16'h4400, 1'b0, 1'b0};
      default:              return {16'h3555, 1'b0, 1'b0};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CWV = (g == 2) ? 3 : 1;
    localparam int NWV = (g == 0) ? 8 : 2;
    logic [NWV-1:0] cnt_w;
    logic [15:0]    sum_r;
    logic           ovf_r, unf_r;

    fpa_operand_sequencer #(.CALC_WAIT(CWV), .CNT_W(NWV)) u_dut (
      .clk_34      (clk_34),
      .rst_34      (rst_34),
      .in_valid_34 (in_valid[g]),
      .in_data_34  (in_data[g]),
      .in_ready_34 (in_ready[g]),
      .Finput1_34  (fin1[g]),
      .Finput2_34  (fin2[g]),
      .FPSUM_34    (sum_r),
      .Ovf_Flag_34 (ovf_r),
      .Unf_Flag_34 (unf_r),
      .res_valid_34(res_valid[g]),
      .res_ready_34(res_ready[g]),
      .res_data_34 (res_data[g]),
      .res_ovf_34  (res_ovf[g]),
      .res_unf_34  (res_unf[g]),
      .res_exc_34  (res_exc[g]),
      .op_cnt_34   (cnt_w)
    );

    assign op_cnt[g] = 8'(cnt_w);

    always @(posedge clk_34) begin
      if (rst_34) {sum_r, ovf_r, unf_r} <= '0;
      else        {sum_r, ovf_r, unf_r} <= add_model(fin1[g], fin2[g]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input int i);
    chk("rst_fin1",  32'(fin1[i]), 32'h0);
    chk("rst_fin2",  32'(fin2[i]), 32'h0);
    chk("rst_data",  32'(res_data[i]), 32'h0);
    chk("rst_flags", {29'h0, res_ovf[i], res_unf[i], res_exc[i]}, 32'h0);
    chk("rst_valid", 32'(res_valid[i]), 32'h0);
    chk("rst_cnt",   32'(op_cnt[i]), 32'h0);
    chk("rst_ready", 32'(in_ready[i]), 32'h1);
  endtask

  // Called at a negedge in IN1; returns at the negedge after the op2 edge.
  task automatic send_pair(input int i, input logic [15:0] a, input logic [15:0] b);
    chk("ready_in1", 32'(in_ready[i]), 32'h1);
    in_valid[i] = 1'b1;
    in_data[i]  = a;
    @(negedge clk_34);
    chk("ready_in2", 32'(in_ready[i]), 32'h1);
    chk("fin1", 32'(fin1[i]), 32'(a));
    in_data[i] = b;
    @(negedge clk_34);
    in_valid[i] = 1'b0;
    chk("ready_calc", 32'(in_ready[i]), 32'h0);
    chk("fin2", 32'(fin2[i]), 32'(b));
  endtask

  task automatic wait_result(input int i, input int lat, input logic [15:0] sum,
                             input logic ovf, input logic unf, input logic exc);
    int cycles = 0;
    while (res_valid[i] !== 1'b1 && cycles < 40) begin
      @(negedge clk_34);
      cycles++;
    end
    chk("latency",  32'(cycles), 32'(lat));
    chk("res_data", 32'(res_data[i]), 32'(sum));
    chk("res_ovf",  32'(res_ovf[i]), 32'(ovf));
    chk("res_unf",  32'(res_unf[i]), 32'(unf));
    chk("res_exc",  32'(res_exc[i]), 32'(exc));
  endtask

  task automatic release_res(input int i, input logic [7:0] cnt, input logic [15:0] sum);
    res_ready[i] = 1'b1;
    @(negedge clk_34);
    res_ready[i] = 1'b0;
    chk("valid_drop", 32'(res_valid[i]), 32'h0);
    chk("op_cnt",     32'(op_cnt[i]), 32'(cnt));
    chk("back_in1",   32'(in_ready[i]), 32'h1);
    chk("data_held",  32'(res_data[i]), 32'(sum));
  endtask

  initial begin
    rst_34 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; res_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk_34);
    for (int i = 0; i < 3; i++) chk_cleared(i);
    rst_34 = 1'b0;

    send_pair(0, 16'h3C00, 16'h3C00);
    wait_result(0, 2, 16'h4000, 1'b0, 1'b0, 1'b0);
    release_res(0, 8'd1, 16'h4000);

    send_pair(0, 16'h3C00, 16'hBC00);
    wait_result(0, 2, 16'h0000, 1'b0, 1'b1, 1'b0);
    release_res(0, 8'd2, 16'h0000);

    send_pair(0, 16'h7BFF, 16'h7BFF);
    wait_result(0, 2, 16'h0000, 1'b1, 1'b0, 1'b0);
    release_res(0, 8'd3, 16'h0000);

    send_pair(0, 16'h7C00, 16'h3C00);
    wait_result(0, 2, 16'h7C00, 1'b0, 1'b0, 1'b1);
    release_res(0, 8'd4, 16'h7C00);

    // Backpressure with upstream still pushing words.
    send_pair(0, 16'h3C00, 16'h3C00);
    wait_result(0, 2, 16'h4000, 1'b0, 1'b0, 1'b0);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_34);
      chk("bp_valid", 32'(res_valid[0]), 32'h1);
      chk("bp_data",  32'(res_data[0]), 32'h4000);
      chk("bp_ready", 32'(in_ready[0]), 32'h0);
      chk("bp_fin1",  32'(fin1[0]), 32'h3C00);
      chk("bp_fin2",  32'(fin2[0]), 32'h3C00);
      chk("bp_cnt",   32'(op_cnt[0]), 32'd4);
    end
    in_valid[0] = 1'b0;
    release_res(0, 8'd5, 16'h4000);

    // Reset in CALC discards the pending result.
    send_pair(0, 16'h3C00, 16'h3C00);
    rst_34 = 1'b1;
    @(negedge clk_34);
    rst_34 = 1'b0;
    chk_cleared(0);
    repeat (3) @(negedge clk_34);
    chk("no_stale_valid", 32'(res_valid[0]), 32'h0);
    send_pair(0, 16'h4000, 16'h4000);
    wait_result(0, 2, 16'h4400, 1'b0, 1'b0, 1'b0);
    release_res(0, 8'd1, 16'h4400);

    // Two-bit counter wraps, for both wait settings.
    for (int i = 1; i < 3; i++) begin
      for (int n = 1; n <= 4; n++) begin
        send_pair(i, 16'h3C00, 16'h3C00);
        wait_result(i, (i == 2) ? 4 : 2, 16'h4000, 1'b0, 1'b0, 1'b0);
        release_res(i, 8'(n % 4), 16'h4000);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
